// File: rtl/tof_frame_reader_if.sv
// Sample stream from the ToF frame reader to the plane/surface calculator.
// The master drives the radius samples; the slave returns out_ready.
interface tof_frame_reader_if #(
    parameter int DATA_W = 16,
    parameter int SW     = 2
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_first;
    logic              out_last;
    logic [SW-1:0]     out_sens;

    modport master (
        output out_data, out_valid, out_first, out_last, out_sens,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_first, out_last, out_sens,
        output out_ready
    );
endinterface

// File: rtl/tof_frame_reader.sv
// tof_frame_reader: once a complete frame sits in BRAM, walk the N_SENS sensor
// blocks of GRID x GRID radii, stream each block to the calculator and wait for
// its result before moving on to the next sensor.
// Optional build macro TOF_SENS_MASK_EN adds a sens_mask input; sensors whose
// mask bit is 0 are skipped entirely.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a drdy rising edge
// S_READ    | issuing BRAM reads for the current sensor, credit-limited
// S_DRAIN   | all reads issued, waiting for the last sample to be taken
// S_WAIT_CALC | block streamed, waiting for calc_rdy
// S_DONE    | frame finished, frame_done follows in the next cycle
module tof_frame_reader #(
    parameter int  N_SENS   = 4,
    parameter int  GRID     = 8,
    parameter int  DATA_W   = 16,
    parameter int  BRAM_LAT = 1,
    localparam int SW       = (N_SENS > 1) ? $clog2(N_SENS) : 1,
    localparam int GW       = $clog2(GRID),
    localparam int ADDR_W   = SW + 2*GW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drdy,
`ifdef TOF_SENS_MASK_EN
    input  logic [N_SENS-1:0] sens_mask,
`endif
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [DATA_W-1:0] bram_dout,
    tof_frame_reader_if.master strm,
    input  logic              calc_rdy,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun
);
    // FIFO holds every sample that can be in flight, so credits never overflow it
    localparam int DEPTH = BRAM_LAT + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int RCW   = 2 * GW;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_DRAIN, S_WAIT_CALC, S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [SW-1:0]       r_sens, w_sens_nxt;
    logic [RCW-1:0]      r_rc;
    logic [RCW-1:0]      r_out_idx;
    logic [CW-1:0]       r_credit;
    logic [BRAM_LAT-1:0] r_vld_pipe;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [PW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_drdy_q, r_armed;
    logic                r_frame_done, r_overrun;
    logic                w_rise, w_issue, w_push, w_pop;
    logic                w_first_ok, w_next_ok;
    logic [SW-1:0]       w_first_sens, w_next_sens;

    // r_armed masks a drdy that is already high when reset is released
    assign w_rise  = drdy & ~r_drdy_q & r_armed;
    assign w_pop   = strm.out_valid & strm.out_ready;
    assign w_push  = r_vld_pipe[BRAM_LAT-1];
    // a pop in the same cycle frees a credit, keeping 1 sample/cycle under full ready
    assign w_issue = (r_state == S_READ) && ((r_credit < CW'(DEPTH)) || w_pop);

    assign bram_en   = w_issue;
    assign bram_addr = {r_sens, r_rc};

    assign strm.out_valid = (r_count != '0);
    assign strm.out_data  = strm.out_valid ? r_mem[r_rd_ptr] : '0;
    assign strm.out_first = strm.out_valid && (r_out_idx == '0);
    assign strm.out_last  = strm.out_valid && (r_out_idx == '1);
    assign strm.out_sens  = r_sens;

    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

`ifdef TOF_SENS_MASK_EN
    logic [N_SENS-1:0] r_mask;

    // latch the mask when a frame is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             r_mask <= '0;
        else if ((r_state == S_IDLE) && w_rise) r_mask <= sens_mask;
    end

    // lowest enabled sensor for frame start, and next enabled sensor above r_sens
    always_comb begin
        w_first_ok   = 1'b0;
        w_first_sens = '0;
        w_next_ok    = 1'b0;
        w_next_sens  = '0;
        for (int i = N_SENS - 1; i >= 0; i--) begin
            if (sens_mask[i]) begin
                w_first_ok   = 1'b1;
                w_first_sens = SW'(i);
            end
            if (r_mask[i] && (i > int'(r_sens))) begin
                w_next_ok   = 1'b1;
                w_next_sens = SW'(i);
            end
        end
    end
`else
    // every sensor is processed in index order
    always_comb begin
        w_first_ok   = 1'b1;
        w_first_sens = '0;
        w_next_ok    = (r_sens != SW'(N_SENS - 1));
        w_next_sens  = r_sens + SW'(1);
    end
`endif

    // state and current sensor registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sens  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sens  <= w_sens_nxt;
        end
    end

    // next-state decode
    always_comb begin
        w_state_nxt = r_state;
        w_sens_nxt  = r_sens;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    if (w_first_ok) begin
                        w_state_nxt = S_READ;
                        w_sens_nxt  = w_first_sens;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_READ:  if (w_issue && (r_rc == '1)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_credit == '0)          w_state_nxt = S_WAIT_CALC;
            S_WAIT_CALC: begin
                if (calc_rdy) begin
                    if (w_next_ok) begin
                        w_state_nxt = S_READ;
                        w_sens_nxt  = w_next_sens;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // drdy edge detect and registered status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drdy_q     <= 1'b0;
            r_armed      <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_drdy_q     <= drdy;
            r_armed      <= 1'b1;
            r_frame_done <= (r_state == S_DONE);
            r_overrun    <= w_rise & busy;
        end
    end

    // read address, output sample index and issued-but-unconsumed credits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rc      <= '0;
            r_out_idx <= '0;
            r_credit  <= '0;
        end else begin
            if (w_issue) r_rc <= r_rc + RCW'(1);
            if (w_pop)   r_out_idx <= r_out_idx + RCW'(1);
            case ({w_issue, w_pop})
                2'b10:   r_credit <= r_credit + CW'(1);
                2'b01:   r_credit <= r_credit - CW'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    // tracks which cycle the BRAM data for each issued read becomes valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_issue;
            for (int i = 1; i < BRAM_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= bram_dout;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: doc/tof_frame_reader.md
Name: tof_frame_reader

Overview:
- Parametrised successor to the single-sensor ToF read FSM.
- Once the BRAM filler signals a complete frame, it walks the BRAM holding N_SENS ToF sensors of GRID x GRID radii.
- Streams each sensor's radii to the plane/surface calculator over a valid/ready stream, absorbing BRAM read latency and backpressure.
- Waits for the calculator's result before starting the next sensor; reports frame completion and overrun.

Parameters:
- N_SENS, 4, number of sensors in the frame (>=1).
- GRID, 8, sensor grid side (power of 2, >=2); GRID*GRID samples per sensor.
- DATA_W, 16, radius width.
- BRAM_LAT, 1, BRAM read latency in cycles (1..3).
- SW, $clog2(N_SENS) (min 1); GW, $clog2(GRID); ADDR_W, SW+2*GW (derived localparams).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- drdy  in  1  frame written to BRAM (level).
- bram_addr  out  ADDR_W  read address = {sensor, row, col}.
- bram_en  out  1  read enable.
- bram_dout  in  DATA_W  read data, valid BRAM_LAT cycles after bram_en.
- out_data  out  DATA_W  radius sample.
- out_valid  out  1  sample valid.
- out_ready  in  1  calculator accepts sample.
- out_first  out  1  first sample of a sensor (row 0, col 0), qualified by out_valid.
- out_last  out  1  last sample of a sensor, qualified by out_valid.
- out_sens  out  SW  sensor index of current sample/block.
- calc_rdy  in  1  calculator result ready (1-cycle pulse).
- frame_done  out  1  1-cycle pulse after last sensor's calc_rdy.
- busy  out  1  high from frame accept to frame_done.
- overrun  out  1  1-cycle pulse on drdy rising edge while busy.

Behaviour:
- Reset: all outputs 0, bram_addr 0, state IDLE, FIFO empty, armed=0.
- drdy edge: registered drdy_q. Rising edge = drdy & ~drdy_q. drdy already high at reset release is not an edge.
- States:
  - IDLE: on rising edge -> READ, sensor 0, busy=1.
  - READ: issue one address per cycle while the credit counter (issued-but-unconsumed) < BRAM_LAT+1.
    - Row-major col inner, row outer.
    - After issuing col=GRID-1, row=GRID-1 -> DRAIN.
  - DRAIN: wait until the FIFO is empty and the last sample is accepted -> WAIT_CALC.
  - WAIT_CALC: on calc_rdy:
    - if sensor==N_SENS-1 -> DONE;
    - else sensor+1 -> READ.
  - DONE: frame_done=1 for one cycle, busy=0 -> IDLE.
- FIFO: depth BRAM_LAT+1, captures bram_dout in the cycle BRAM_LAT after bram_en. It never overflows thanks to the credit limit.
- Throughput: out_ready held 1 gives 1 sample/cycle. First out_valid occurs BRAM_LAT+1 cycles after leaving IDLE.
- Stream rules:
  - out_data, out_first, out_last and out_sens are stable while out_valid & ~out_ready.
  - out_valid never drops without a handshake.
- calc_rdy outside WAIT_CALC is ignored.
- drdy rising edge while busy: overrun pulse; the frame in progress continues; the edge is not queued.
- Reset asserted mid-frame: immediate return to the reset state; no frame_done.
- N_SENS=1: SW=1, out_sens is always 0.

Optional Feature:
- Macro TOF_SENS_MASK_EN.
- With it: extra input sens_mask [N_SENS-1:0], sampled on frame accept.
  - Sensors whose bit is 0 are skipped: no reads, no stream, no calc_rdy wait.
  - If the mask is all-zero: IDLE -> DONE, frame_done 2 cycles after the edge.
- Without it: no port; all sensors are processed.

Test Plan:
- Default params, out_ready=1, calc_rdy pulsed 3 cycles after each out_last -> 4 blocks of 64 samples, addresses 0..255 in order, out_first/out_last on samples 0 and 63 of each block, frame_done once, busy low afterwards.
- BRAM_LAT=3, out_ready toggling 1/0 each cycle -> no lost or duplicated samples; out_data sequence equals the BRAM contents in order; FIFO never exceeds 4 entries.
- drdy held high from reset release -> no frame. Drop then raise drdy -> exactly one frame.
- Second drdy rising edge during sensor 2 -> overrun pulse, frame completes normally, no second frame starts.
- Reset pulled low during sensor 1 streaming -> out_valid=0, busy=0 in the same cycle. The next drdy edge restarts at address 0.
- TOF_SENS_MASK_EN, sens_mask=4'b1010 -> only sensors 1 and 3 streamed (addresses 64..127, 192..255); mask 0 -> frame_done 2 cycles after the edge.
